// File: rtl/sync_ram_read_ctrl.sv
// rtl/sync_ram_read_ctrl.sv - dual-port read controller for a synchronous RAM with response buffering and write forwarding

// One read port: tracks the request in flight, resolves its data and buffers it
// in a 2-entry FIFO so responses can stall without losing RAM read data.
module sync_ram_read_port #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  logic                  inflight_q;
  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic [1:0]            occ;
  logic                  fifo_empty;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  collide;
  logic [DATA_WIDTH-1:0] resolved;

  // Occupancy counts the slot reserved by the in-flight read, so the FIFO can
  // always absorb it; ready depends on registered state only.
  assign occ        = count_q + {1'b0, inflight_q};
  assign req_ready  = (occ < 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign accept     = req_valid && req_ready;

  // A same-cycle write to the requested address overrides the RAM read data
  // when forwarding is enabled; the RAM itself is assumed read-first.
  assign collide  = (WRITE_FIRST != 0) && wr_en && (wr_addr == req_addr);
  assign resolved = fwd_hit_q ? fwd_data_q : rd_data;

  // Buffered data always leaves before the in-flight one to keep ordering.
  assign resp_valid = !fifo_empty || inflight_q;
  assign resp_data  = !fifo_empty ? fifo_q[rd_ptr_q] :
                      (inflight_q ? resolved : '0);

  assign pop  = !fifo_empty && resp_ready;
  assign push = inflight_q && (!fifo_empty || !resp_ready);

  // Control state: in-flight flag, forwarding latch and FIFO pointers/count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inflight_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= accept;
      fwd_hit_q  <= accept && collide;
      if (accept) begin
        fwd_data_q <= wr_data;
      end
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage; contents are only visible through count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= resolved;
    end
  end

endmodule

// Top level: write port passes straight through to the RAM, two independent read ports.
module sync_ram_read_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_FIRST = 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] WrAddr_DI,
  input  logic [DATA_WIDTH-1:0] WrData_DI,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] WrAddr_DO,
  output logic [DATA_WIDTH-1:0] WrData_DO,
  input  logic                  ReqValid_SI_0,
  output logic                  ReqReady_SO_0,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI_0,
  output logic                  RespValid_SO_0,
  input  logic                  RespReady_SI_0,
  output logic [DATA_WIDTH-1:0] RespData_DO_0,
  output logic [ADDR_WIDTH-1:0] RdAddr_DO_0,
  input  logic [DATA_WIDTH-1:0] RdData_DI_0,
  input  logic                  ReqValid_SI_1,
  output logic                  ReqReady_SO_1,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI_1,
  output logic                  RespValid_SO_1,
  input  logic                  RespReady_SI_1,
  output logic [DATA_WIDTH-1:0] RespData_DO_1,
  output logic [ADDR_WIDTH-1:0] RdAddr_DO_1,
  input  logic [DATA_WIDTH-1:0] RdData_DI_1
);

  assign WrEn_SO     = WrEn_SI;
  assign WrAddr_DO   = WrAddr_DI;
  assign WrData_DO   = WrData_DI;
  assign RdAddr_DO_0 = ReqAddr_DI_0;
  assign RdAddr_DO_1 = ReqAddr_DI_1;

  sync_ram_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_FIRST(WRITE_FIRST)
  ) u_port0 (
    .clk       (Clk_CI),
    .resetn    (Rst_RBI),
    .wr_en     (WrEn_SI),
    .wr_addr   (WrAddr_DI),
    .wr_data   (WrData_DI),
    .req_valid (ReqValid_SI_0),
    .req_ready (ReqReady_SO_0),
    .req_addr  (ReqAddr_DI_0),
    .resp_valid(RespValid_SO_0),
    .resp_ready(RespReady_SI_0),
    .resp_data (RespData_DO_0),
    .rd_data   (RdData_DI_0)
  );

  sync_ram_read_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_FIRST(WRITE_FIRST)
  ) u_port1 (
    .clk       (Clk_CI),
    .resetn    (Rst_RBI),
    .wr_en     (WrEn_SI),
    .wr_addr   (WrAddr_DI),
    .wr_data   (WrData_DI),
    .req_valid (ReqValid_SI_1),
    .req_ready (ReqReady_SO_1),
    .req_addr  (ReqAddr_DI_1),
    .resp_valid(RespValid_SO_1),
    .resp_ready(RespReady_SI_1),
    .resp_data (RespData_DO_1),
    .rd_data   (RdData_DI_1)
  );

endmodule

// File: tb/tb_sync_ram_read_ctrl.sv
// tb/tb_sync_ram_read_ctrl.sv - directed self-checking bench for sync_ram_read_ctrl

module tb_sync_ram_read_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          init_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          req_valid0, req_valid1;
  logic [AW-1:0] req_addr0, req_addr1;
  logic          resp_ready0, resp_ready1;
  logic [DW-1:0] rd0, rd1, rdb0;

  logic          a_wr_en;
  logic [AW-1:0] a_wr_addr;
  logic [DW-1:0] a_wr_data;
  logic          a_req_ready0, a_req_ready1;
  logic          a_resp_valid0, a_resp_valid1;
  logic [DW-1:0] a_resp_data0, a_resp_data1;
  logic [AW-1:0] a_rd_addr0, a_rd_addr1;

  logic          b_wr_en;
  logic [AW-1:0] b_wr_addr;
  logic [DW-1:0] b_wr_data;
  logic          b_req_ready0, b_req_ready1;
  logic          b_resp_valid0, b_resp_valid1;
  logic [DW-1:0] b_resp_data0, b_resp_data1;
  logic [AW-1:0] b_rd_addr0, b_rd_addr1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:1023];

  // Read-first synchronous RAM shared by both controllers
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
      mem[9] <= 32'h0000_0011;
    end else if (a_wr_en) begin
      mem[a_wr_addr] <= a_wr_data;
    end
    rd0  <= mem[a_rd_addr0];
    rd1  <= mem[a_rd_addr1];
    rdb0 <= mem[b_rd_addr0];
  end

  sync_ram_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_FIRST(1)) dut_a (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .WrEn_SI(wr_en), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
    .WrEn_SO(a_wr_en), .WrAddr_DO(a_wr_addr), .WrData_DO(a_wr_data),
    .ReqValid_SI_0(req_valid0), .ReqReady_SO_0(a_req_ready0), .ReqAddr_DI_0(req_addr0),
    .RespValid_SO_0(a_resp_valid0), .RespReady_SI_0(resp_ready0), .RespData_DO_0(a_resp_data0),
    .RdAddr_DO_0(a_rd_addr0), .RdData_DI_0(rd0),
    .ReqValid_SI_1(req_valid1), .ReqReady_SO_1(a_req_ready1), .ReqAddr_DI_1(req_addr1),
    .RespValid_SO_1(a_resp_valid1), .RespReady_SI_1(resp_ready1), .RespData_DO_1(a_resp_data1),
    .RdAddr_DO_1(a_rd_addr1), .RdData_DI_1(rd1)
  );

  sync_ram_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_FIRST(0)) dut_b (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .WrEn_SI(wr_en), .WrAddr_DI(wr_addr), .WrData_DI(wr_data),
    .WrEn_SO(b_wr_en), .WrAddr_DO(b_wr_addr), .WrData_DO(b_wr_data),
    .ReqValid_SI_0(req_valid0), .ReqReady_SO_0(b_req_ready0), .ReqAddr_DI_0(req_addr0),
    .RespValid_SO_0(b_resp_valid0), .RespReady_SI_0(resp_ready0), .RespData_DO_0(b_resp_data0),
    .RdAddr_DO_0(b_rd_addr0), .RdData_DI_0(rdb0),
    .ReqValid_SI_1(1'b0), .ReqReady_SO_1(b_req_ready1), .ReqAddr_DI_1('0),
    .RespValid_SO_1(b_resp_valid1), .RespReady_SI_1(1'b1), .RespData_DO_1(b_resp_data1),
    .RdAddr_DO_1(b_rd_addr1), .RdData_DI_1('0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stall scenario table, bit c = cycle c
  bit [7:0] st_v     = 8'b0000_0011;
  bit [7:0] st_rr    = 8'b1110_0000;
  bit [7:0] st_ready = 8'b1100_0011;
  bit [7:0] st_val   = 8'b0111_1110;

  initial begin
    rst_n = 1'b0; init_req = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid0 = 1'b0; req_valid1 = 1'b0; req_addr0 = '0; req_addr1 = '0;
    resp_ready0 = 1'b1; resp_ready1 = 1'b1;
    tick();
    tick();
    init_req = 1'b0;
    #1;
    check("rst_ready0", a_req_ready0, 32'd1);
    check("rst_ready1", a_req_ready1, 32'd1);
    check("rst_valid0", a_resp_valid0, 32'd0);
    check("rst_valid1", a_resp_valid1, 32'd0);
    check("rst_data0", a_resp_data0, 32'd0);
    check("rst_data1", a_resp_data1, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready0", a_req_ready0, 32'd1);
    check("post_rst_valid0", a_resp_valid0, 32'd0);

    // back-to-back streaming on port 0
    for (int k = 0; k < 10; k++) begin
      req_valid0 = (k < 8); req_addr0 = k[AW-1:0]; resp_ready0 = 1'b1;
      #1;
      check($sformatf("b2b_ready_%0d", k), a_req_ready0, 32'd1);
      if (k >= 1 && k <= 8) begin
        check($sformatf("b2b_valid_%0d", k), a_resp_valid0, 32'd1);
        check($sformatf("b2b_data_%0d", k), a_resp_data0, 32'h1000_0000 + k - 1);
        check($sformatf("b2b_data_rf_%0d", k), b_resp_data0, 32'h1000_0000 + k - 1);
      end else begin
        check($sformatf("b2b_idle_%0d", k), a_resp_valid0, 32'd0);
      end
      tick();
    end

    // stall with two outstanding
    for (int c = 0; c < 8; c++) begin
      req_valid0 = st_v[c]; req_addr0 = (c == 0) ? 10'd3 : 10'd4; resp_ready0 = st_rr[c];
      #1;
      check($sformatf("stall_ready_%0d", c), a_req_ready0, {31'd0, st_ready[c]});
      check($sformatf("stall_valid_%0d", c), a_resp_valid0, {31'd0, st_val[c]});
      check($sformatf("stall_data_%0d", c), a_resp_data0,
            (c >= 1 && c <= 5) ? 32'h1000_0003 : ((c == 6) ? 32'h1000_0004 : 32'd0));
      tick();
    end

    // read/write collision and non-colliding write
    req_valid0 = 1'b1; req_addr0 = 10'd5; resp_ready0 = 1'b1;
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hDEAD_BEEF;
    #1;
    check("wr_pass_en", a_wr_en, 32'd1);
    check("wr_pass_addr", a_wr_addr, 32'd5);
    check("wr_pass_data", a_wr_data, 32'hDEAD_BEEF);
    check("rd_pass_addr", a_rd_addr0, 32'd5);
    tick();
    req_addr0 = 10'd7; wr_addr = 10'd6; wr_data = 32'h1234_5678;
    #1;
    check("coll_wf1", a_resp_data0, 32'hDEAD_BEEF);
    check("coll_wf0", b_resp_data0, 32'h1000_0005);
    tick();
    req_valid0 = 1'b0; wr_en = 1'b0;
    #1;
    check("nocoll_wf1", a_resp_data0, 32'h1000_0007);
    check("nocoll_wf0", b_resp_data0, 32'h1000_0007);
    tick();

    // write after accept must not change the response
    req_valid0 = 1'b1; req_addr0 = 10'd9; resp_ready0 = 1'b0;
    tick();
    req_valid0 = 1'b0; wr_en = 1'b1; wr_addr = 10'd9; wr_data = 32'h0000_0022;
    #1;
    check("postwr_valid", a_resp_valid0, 32'd1);
    check("postwr_data_a", a_resp_data0, 32'h0000_0011);
    tick();
    wr_en = 1'b0; resp_ready0 = 1'b1;
    #1;
    check("postwr_data_b", a_resp_data0, 32'h0000_0011);
    tick();
    req_valid0 = 1'b1; req_addr0 = 10'd9;
    #1;
    check("postwr_drained", a_resp_valid0, 32'd0);
    tick();
    req_valid0 = 1'b0;
    #1;
    check("postwr_newval", a_resp_data0, 32'h0000_0022);
    tick();

    // port 0 streams while port 1 is stalled with two pending
    for (int c = 0; c < 13; c++) begin
      req_valid0 = (c < 8); req_addr0 = 10'(30 + c); resp_ready0 = 1'b1;
      req_valid1 = (c < 2); req_addr1 = 10'(20 + c); resp_ready1 = (c >= 10);
      #1;
      check($sformatf("dual_ready0_%0d", c), a_req_ready0, 32'd1);
      if (c >= 1 && c <= 8) begin
        check($sformatf("dual_data0_%0d", c), a_resp_data0, 32'h1000_0000 + 30 + c - 1);
      end else begin
        check($sformatf("dual_valid0_%0d", c), a_resp_valid0, 32'd0);
      end
      check($sformatf("dual_ready1_%0d", c), a_req_ready1, (c < 2 || c >= 11) ? 32'd1 : 32'd0);
      check($sformatf("dual_valid1_%0d", c), a_resp_valid1, (c >= 1 && c <= 11) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 11) begin
        check($sformatf("dual_data1_%0d", c), a_resp_data1,
              (c <= 10) ? 32'h1000_0014 : 32'h1000_0015);
      end
      tick();
    end

    // reset with both ports full
    req_valid0 = 1'b1; req_addr0 = 10'd40; resp_ready0 = 1'b0;
    req_valid1 = 1'b1; req_addr1 = 10'd41; resp_ready1 = 1'b0;
    tick();
    req_addr0 = 10'd42; req_addr1 = 10'd43;
    #1;
    check("full_ready0_c1", a_req_ready0, 32'd1);
    tick();
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    #1;
    check("full_ready0", a_req_ready0, 32'd0);
    check("full_ready1", a_req_ready1, 32'd0);
    check("full_valid0", a_resp_valid0, 32'd1);
    check("full_valid1", a_resp_valid1, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; resp_ready0 = 1'b1; resp_ready1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("mrst_valid0_%0d", c), a_resp_valid0, 32'd0);
      check($sformatf("mrst_valid1_%0d", c), a_resp_valid1, 32'd0);
      check($sformatf("mrst_ready0_%0d", c), a_req_ready0, 32'd1);
      check($sformatf("mrst_ready1_%0d", c), a_req_ready1, 32'd1);
      check($sformatf("mrst_data0_%0d", c), a_resp_data0, 32'd0);
      check($sformatf("mrst_data1_%0d", c), a_resp_data1, 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ram_read_ctrl.md
SYNC_RAM_READ_CTRL -- requirements
Module: sync_ram_read_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width of all data ports.
REQ-003 Parameter WRITE_FIRST, default 1, SHALL select forwarding of same-cycle write data (1) or old RAM contents (0).
REQ-004 Clk_CI  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Rst_RBI  in  1  SHALL be the synchronous, active-low reset.
REQ-006 WrEn_SI, WrAddr_DI, WrData_DI  in  1/ADDR_WIDTH/DATA_WIDTH  SHALL be the write request.
REQ-007 WrEn_SO, WrAddr_DO, WrData_DO  out  1/ADDR_WIDTH/DATA_WIDTH  SHALL be combinational copies of the write inputs, driving the RAM write port.
REQ-008 For p in {0,1}: ReqValid_SI_p  in  1, ReqReady_SO_p  out  1, ReqAddr_DI_p  in  ADDR_WIDTH  SHALL form the read request handshake.
REQ-009 For p in {0,1}: RespValid_SO_p  out  1, RespReady_SI_p  in  1, RespData_DO_p  out  DATA_WIDTH  SHALL form the read response handshake.
REQ-010 For p in {0,1}: RdAddr_DO_p  out  ADDR_WIDTH  SHALL equal ReqAddr_DI_p combinationally; RdData_DI_p  in  DATA_WIDTH  SHALL be RAM read data, valid one cycle after the address.

Function (per port p, ports fully independent)
REQ-011 A request SHALL be accepted in a cycle where ReqValid_SI_p and ReqReady_SO_p are both 1.
REQ-012 State: inflight flag (accepted last cycle), 2-entry FIFO of captured data, occupancy occ = inflight + FIFO count, range 0..2.
REQ-013 ReqReady_SO_p SHALL be 1 iff occ < 2, evaluated from registered state only (no path from RespReady_SI_p or ReqValid_SI_p).
REQ-014 Accepted in cycle t: inflight SHALL be 1 in cycle t+1; data for that request SHALL be resolved in t+1.
REQ-015 Resolved data SHALL be the latched WrData_DI of cycle t if WRITE_FIRST=1 and WrEn_SI=1 and WrAddr_DI=ReqAddr_DI_p in cycle t; otherwise RdData_DI_p in t+1.
REQ-016 Writes after cycle t SHALL NOT alter data for a request accepted in t.
REQ-017 FIFO empty and inflight=1: RespValid_SO_p=1, RespData_DO_p = resolved data (latency 1 cycle); if RespReady_SI_p=0 it SHALL be pushed to the FIFO.
REQ-018 FIFO non-empty: RespValid_SO_p=1, RespData_DO_p = FIFO head; a handshake pops the head; inflight data SHALL be pushed in the same cycle.
REQ-019 Simultaneous push and pop SHALL keep count; responses SHALL leave in acceptance order.
REQ-020 RespValid_SO_p=0 when FIFO empty and inflight=0; RespData_DO_p SHALL then be 0.
REQ-021 Once RespValid_SO_p=1, it and RespData_DO_p SHALL stay stable until the handshake.
REQ-022 With RespReady_SI_p held 1 the port SHALL sustain one request and one response per cycle.
REQ-023 FIFO overflow SHALL be impossible by REQ-013; FIFO pointers SHALL wrap modulo 2.

Reset
REQ-024 While Rst_RBI=0 at a clock edge: occ=0, inflight=0, FIFO empty, latched write data cleared.
REQ-025 Outputs during/after reset: ReqReady_SO_p=1, RespValid_SO_p=0, RespData_DO_p=0.
REQ-026 Reset mid-operation SHALL discard in-flight and buffered data; no response for them SHALL ever appear.

Verification
REQ-027 Back-to-back: port 0 requests addr 0..7 every cycle, RespReady=1 -> RespValid from cycle 1, data mem[0..7] in order, ReqReady never 0.
REQ-028 Stall: accept addr 3, 4; RespReady=0 for 5 cycles -> ReqReady 0 from cycle 2, RespData holds mem[3]; release -> mem[3] then mem[4], ReqReady returns 1.
REQ-029 Collision: same cycle write 0xDEADBEEF to addr 5 and read addr 5 -> response 0xDEADBEEF (WRITE_FIRST=1), old value (WRITE_FIRST=0).
REQ-030 Post-accept write: read addr 9 (holds 0x11), stall response, write 0x22 to addr 9 -> response 0x11.
REQ-031 Dual-port: port 0 streams, port 1 stalled with 2 pending -> port 0 throughput unaffected, port 1 order preserved.
REQ-032 Reset with occ=2 on both ports -> next cycle RespValid=0, ReqReady=1, no stale responses afterward.
